// File: rtl/mmio_timer_responder.sv
// Machine-timer responder on the data-memory bus: 64-bit mtime/mtimecmp, prescaler, enable, level interrupt.
// Optional macro TIMER_LATCH_HI_EN: a read of mtime_lo latches mtime_hi so a following read of 0x04 is coherent.
module mmio_timer_responder #(
    parameter int                      DATA_WIDTH      = 32,
    parameter int                      ADDRESS_BITS    = 32,
    parameter logic [ADDRESS_BITS-1:0] BASE_ADDRESS    = 32'h0200_0000,
    parameter int                      PRESCALE_BITS   = 16,
    parameter int                      SCAN_CYCLES_MIN = 0,
    parameter int                      SCAN_CYCLES_MAX = 1000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      d_mem_read,
    input  logic                      d_mem_write,
    input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
    input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
    input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
    output logic [DATA_WIDTH-1:0]     d_mem_data_out,
    output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
    output logic                      d_mem_valid,
    output logic                      d_mem_ready,
    output logic                      timer_interrupt,
    input  logic                      scan
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    localparam logic [PRESCALE_BITS-1:0] PCNT_ONE = 1;

    state_t                   r_state;
    state_t                   w_state_next;

    logic [63:0]              r_mtime;
    logic [63:0]              r_mtimecmp;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic [PRESCALE_BITS-1:0] r_pcount;
    logic                     r_enable;
    logic                     r_irq;
    logic [DATA_WIDTH-1:0]    r_data_out;
    logic [ADDRESS_BITS-1:0]  r_addr_out;

    logic [63:0]              w_mtime_next;
    logic [63:0]              w_cmp_next;
    logic [PRESCALE_BITS-1:0] w_pre_next;
    logic [PRESCALE_BITS-1:0] w_pcount_next;
    logic                     w_en_next;
    logic                     w_tick;
    logic                     w_in_window;
    logic                     w_accept;
    logic                     w_write;
    logic [2:0]               w_offset;
    logic [DATA_WIDTH-1:0]    w_byte_mask;
    logic [DATA_WIDTH-1:0]    w_rdata;
    logic [31:0]              w_hi_read;
    logic [31:0]              w_mtime_lo_wr;
    logic [31:0]              w_mtime_hi_wr;
    logic [31:0]              w_cmp_lo_wr;
    logic [31:0]              w_cmp_hi_wr;
    logic                     w_scan_unused;

    // The scan trace is a simulation-only facility; the pin has no effect in hardware.
    assign w_scan_unused = scan & (SCAN_CYCLES_MAX >= SCAN_CYCLES_MIN);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_lane_mask
            assign w_byte_mask[gi*8 +: 8] = {8{d_mem_byte_en[gi]}};
        end
    endgenerate

    assign w_in_window = (d_mem_address_in[ADDRESS_BITS-1:5] == BASE_ADDRESS[ADDRESS_BITS-1:5]);
    assign w_accept    = (r_state == S_IDLE) && (d_mem_read || d_mem_write) && w_in_window;
    assign w_write     = w_accept && d_mem_write;
    assign w_offset    = d_mem_address_in[4:2];

    assign w_mtime_lo_wr = (r_mtime[31:0]     & ~w_byte_mask) | (d_mem_data_in & w_byte_mask);
    assign w_mtime_hi_wr = (r_mtime[63:32]    & ~w_byte_mask) | (d_mem_data_in & w_byte_mask);
    assign w_cmp_lo_wr   = (r_mtimecmp[31:0]  & ~w_byte_mask) | (d_mem_data_in & w_byte_mask);
    assign w_cmp_hi_wr   = (r_mtimecmp[63:32] & ~w_byte_mask) | (d_mem_data_in & w_byte_mask);

    assign w_tick = r_enable && (r_pcount == r_prescale);

`ifdef TIMER_LATCH_HI_EN
    logic [31:0] r_mtime_hi_shadow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mtime_hi_shadow <= '0;
        end else if (w_accept && d_mem_read && !d_mem_write && (w_offset == 3'd0)) begin
            r_mtime_hi_shadow <= r_mtime[63:32];
        end
    end

    assign w_hi_read = r_mtime_hi_shadow;
`else
    assign w_hi_read = r_mtime[63:32];
`endif

    always_comb begin
        w_rdata = '0;
        case (w_offset)
            3'd0:    w_rdata = r_mtime[31:0];
            3'd1:    w_rdata = w_hi_read;
            3'd2:    w_rdata = r_mtimecmp[31:0];
            3'd3:    w_rdata = r_mtimecmp[63:32];
            3'd4:    w_rdata[PRESCALE_BITS-1:0] = r_prescale;
            3'd5:    w_rdata[0] = r_enable;
            default: w_rdata = '0;
        endcase
    end

    // A bus write to either mtime half replaces the whole update, so a coincident tick is lost.
    always_comb begin
        w_pcount_next = r_pcount;
        if (r_enable) begin
            w_pcount_next = w_tick ? '0 : r_pcount + PCNT_ONE;
        end
        w_mtime_next = w_tick ? r_mtime + 64'd1 : r_mtime;
        w_cmp_next   = r_mtimecmp;
        w_pre_next   = r_prescale;
        w_en_next    = r_enable;
        if (w_write) begin
            case (w_offset)
                3'd0: w_mtime_next = {r_mtime[63:32], w_mtime_lo_wr};
                3'd1: w_mtime_next = {w_mtime_hi_wr, r_mtime[31:0]};
                3'd2: w_cmp_next   = {r_mtimecmp[63:32], w_cmp_lo_wr};
                3'd3: w_cmp_next   = {w_cmp_hi_wr, r_mtimecmp[31:0]};
                3'd4: w_pre_next   = (r_prescale & ~w_byte_mask[PRESCALE_BITS-1:0])
                                   | (d_mem_data_in[PRESCALE_BITS-1:0] & w_byte_mask[PRESCALE_BITS-1:0]);
                3'd5: begin
                    w_en_next = d_mem_byte_en[0] ? d_mem_data_in[0] : r_enable;
                    if (!w_en_next) begin
                        w_pcount_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Reset during RESP suppresses the strobe in that same cycle.
    always_comb begin
        d_mem_ready = (r_state == S_IDLE);
        d_mem_valid = (r_state == S_RESP) && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_prescale <= '0;
            r_pcount   <= '0;
            r_enable   <= 1'b0;
            r_irq      <= 1'b0;
            r_data_out <= '0;
            r_addr_out <= '0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_cmp_next;
            r_prescale <= w_pre_next;
            r_pcount   <= w_pcount_next;
            r_enable   <= w_en_next;
            r_irq      <= (w_mtime_next >= w_cmp_next);
            if (w_accept) begin
                r_data_out <= w_rdata;
                r_addr_out <= d_mem_address_in;
            end
        end
    end

    assign d_mem_data_out    = r_data_out;
    assign d_mem_address_out = r_addr_out;
    assign timer_interrupt   = r_irq;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Randomized bench for mmio_timer_responder with a register-level reference model of the timer.
module tb_mmio_timer_responder;

    localparam logic [31:0] BASE     = 32'h0200_0000;
    localparam int          SCAN_MIN = 0;
    localparam int          SCAN_MAX = 1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [3:0]  d_mem_byte_en;
    logic [31:0] d_mem_address_in;
    logic [31:0] d_mem_data_in;
    logic [31:0] d_mem_data_out;
    logic [31:0] d_mem_address_out;
    logic        d_mem_valid;
    logic        d_mem_ready;
    logic        timer_interrupt;
    logic        scan;

    always #5 clock = ~clock;

    mmio_timer_responder dut (
        .clock             (clock),
        .reset             (reset),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_byte_en     (d_mem_byte_en),
        .d_mem_address_in  (d_mem_address_in),
        .d_mem_data_in     (d_mem_data_in),
        .d_mem_data_out    (d_mem_data_out),
        .d_mem_address_out (d_mem_address_out),
        .d_mem_valid       (d_mem_valid),
        .d_mem_ready       (d_mem_ready),
        .timer_interrupt   (timer_interrupt),
        .scan              (scan)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cycle_count   = 0;

    // Reference model state: the architectural registers plus the pending response.
    logic [63:0] m_mtime   = 64'd0;
    logic [63:0] m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [15:0] m_pre     = 16'd0;
    logic [15:0] m_pcnt    = 16'd0;
    logic        m_en      = 1'b0;
    logic        m_irq     = 1'b0;
    logic [31:0] m_shadow  = 32'd0;
    logic        m_pending = 1'b0;
    logic [31:0] m_rdata   = 32'd0;
    logic [31:0] m_raddr   = 32'd0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] reg_value(input int off);
        case (off)
            0:       return m_mtime[31:0];
`ifdef TIMER_LATCH_HI_EN
            1:       return m_shadow;
`else
            1:       return m_mtime[63:32];
`endif
            2:       return m_cmp[31:0];
            3:       return m_cmp[63:32];
            4:       return {16'd0, m_pre};
            5:       return {31'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit rd, input bit wr, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] n_mtime;
        logic [63:0] n_cmp;
        logic [15:0] n_pre;
        logic [15:0] n_pcnt;
        logic        n_en;
        logic [31:0] tmp;
        bit          tick;
        bit          acc;
        int          off;
        if (rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_pre = 16'd0; m_pcnt = 16'd0; m_en = 1'b0;
            m_irq = 1'b0; m_shadow = 32'd0; m_pending = 1'b0;
            return;
        end
        acc     = !m_pending && (rd || wr) && (addr >= BASE) && (addr < BASE + 32'd32);
        tick    = m_en && (m_pcnt == m_pre);
        n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
        n_pcnt  = m_en ? (tick ? 16'd0 : m_pcnt + 16'd1) : m_pcnt;
        n_cmp   = m_cmp;
        n_pre   = m_pre;
        n_en    = m_en;
        if (acc) begin
            off     = int'((addr - BASE) >> 2);
            m_rdata = reg_value(off);
            m_raddr = addr;
            if (wr) begin
                case (off)
                    0: n_mtime = {m_mtime[63:32], merge(m_mtime[31:0], data, be)};
                    1: n_mtime = {merge(m_mtime[63:32], data, be), m_mtime[31:0]};
                    2: n_cmp   = {m_cmp[63:32], merge(m_cmp[31:0], data, be)};
                    3: n_cmp   = {merge(m_cmp[63:32], data, be), m_cmp[31:0]};
                    4: begin tmp = merge({16'd0, m_pre}, data, be); n_pre = tmp[15:0]; end
                    5: begin
                        tmp  = merge({31'd0, m_en}, data, be);
                        n_en = tmp[0];
                        if (!n_en) n_pcnt = 16'd0;
                    end
                    default: ;
                endcase
            end else if (off == 0) begin
                m_shadow = m_mtime[63:32];
            end
        end
        m_pending = acc;
        m_mtime   = n_mtime;
        m_cmp     = n_cmp;
        m_pre     = n_pre;
        m_pcnt    = n_pcnt;
        m_en      = n_en;
        m_irq     = (n_mtime >= n_cmp);
    endtask

    // One clock cycle: drive, check outputs at the falling edge, then advance the model on the rising edge.
    task automatic step(input bit rst, input bit rd, input bit wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] data);
        reset = rst; d_mem_read = rd; d_mem_write = wr; d_mem_byte_en = be;
        d_mem_address_in = addr; d_mem_data_in = data;
        @(negedge clock);
        check("valid", {63'd0, d_mem_valid}, {63'd0, m_pending && !rst});
        check("ready", {63'd0, d_mem_ready}, {63'd0, !m_pending});
        check("irq", {63'd0, timer_interrupt}, {63'd0, m_irq});
        if (m_pending && !rst) begin
            check("rdata", {32'd0, d_mem_data_out}, {32'd0, m_rdata});
            check("raddr", {32'd0, d_mem_address_out}, {32'd0, m_raddr});
            last_rdata = d_mem_data_out;
            $display("txn addr=%h data=%h irq=%b", d_mem_address_out, d_mem_data_out, timer_interrupt);
        end
        @(posedge clock);
        model_edge(rst, rd, wr, be, addr, data);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 32'd0, 32'd0);
    endtask

    task automatic bus_write(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
        step(0, 0, 1, be, BASE + off, data);
        idle(1);
    endtask

    task automatic bus_read(input logic [31:0] off);
        step(0, 1, 0, 4'hF, BASE + off, 32'd0);
        idle(1);
    endtask

    always @(posedge clock) begin
        cycle_count <= cycle_count + 1;
        if (scan && cycle_count >= SCAN_MIN && cycle_count <= SCAN_MAX)
            $display("scan cyc=%0d ready=%b valid=%b rd=%b wr=%b addr=%h",
                     cycle_count, d_mem_ready, d_mem_valid, d_mem_read, d_mem_write, d_mem_address_in);
    end

    initial begin
        logic [31:0] r_addr;
        logic [31:0] r_data;
        int          kind;
        reset = 1'b1; d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_byte_en = 4'h0;
        d_mem_address_in = 32'd0; d_mem_data_in = 32'd0; scan = 1'b0;
        @(posedge clock);
        #1;
        step(1, 0, 0, 4'h0, 32'd0, 32'd0);
        step(1, 0, 0, 4'h0, 32'd0, 32'd0);

        bus_read(32'h14);
        check("ctrl_after_reset", {32'd0, last_rdata}, 64'd0);

        bus_write(32'h08, 32'hAABB_CCDD, 4'b0010);
        bus_read(32'h08);
        check("cmp_lo_byte_en", {32'd0, last_rdata}, {32'd0, 32'hFFFF_CCFF});
        bus_write(32'h08, 32'hFFFF_FFFF, 4'hF);

        step(0, 1, 0, 4'hF, BASE + 32'h40, 32'd0);
        idle(2);

        step(0, 1, 0, 4'hF, BASE, 32'd0);
        step(1, 0, 0, 4'h0, 32'd0, 32'd0);
        idle(1);

        bus_write(32'h10, 32'd3, 4'hF);
        bus_write(32'h14, 32'd1, 4'hF);
        idle(40);
        bus_read(32'h00);
        check("prescale_count", {63'd0, (last_rdata >= 32'd9) && (last_rdata <= 32'd11)}, 64'd1);
        bus_write(32'h14, 32'd0, 4'hF);

        bus_write(32'h10, 32'd0, 4'hF);
        bus_write(32'h04, 32'd0, 4'hF);
        bus_write(32'h00, 32'hFFFF_FFFE, 4'hF);
        bus_write(32'h14, 32'd1, 4'hF);
        idle(2);
        bus_read(32'h04);
        check("mtime_hi_carry", {32'd0, last_rdata}, 64'd1);

        bus_write(32'h04, 32'd0, 4'hF);
        bus_write(32'h00, 32'hFFFF_FFFE, 4'hF);
        bus_read(32'h00);
        check("latch_lo", {32'd0, last_rdata}, {32'd0, 32'hFFFF_FFFF});
        bus_read(32'h04);
`ifdef TIMER_LATCH_HI_EN
        check("latch_hi", {32'd0, last_rdata}, 64'd0);
`else
        check("latch_hi", {32'd0, last_rdata}, 64'd1);
`endif

        bus_write(32'h14, 32'd0, 4'hF);
        bus_write(32'h00, 32'd0, 4'hF);
        bus_write(32'h04, 32'd0, 4'hF);
        bus_write(32'h0C, 32'd0, 4'hF);
        bus_write(32'h08, 32'd20, 4'hF);
        check("irq_before", {63'd0, timer_interrupt}, 64'd0);
        bus_write(32'h14, 32'd1, 4'hF);
        idle(30);
        check("irq_set", {63'd0, timer_interrupt}, 64'd1);
        bus_write(32'h08, 32'd1000, 4'hF);
        check("irq_cleared", {63'd0, timer_interrupt}, 64'd0);

        scan = 1'b1;
        idle(3);
        scan = 1'b0;

        for (int i = 0; i < 600; i++) begin
            kind   = int'($urandom_range(0, 3));
            r_addr = BASE + ($urandom_range(0, 7) * 4) + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) r_addr = ($urandom_range(0, 1) == 0) ? BASE + 32'h40 : BASE - 32'd4;
            r_data = $urandom;
            if (r_addr[4:2] == 3'd4) r_data = $urandom_range(0, 5);
            if (r_addr[4:2] == 3'd2 && $urandom_range(0, 1) == 0) r_data = m_mtime[31:0] + $urandom_range(0, 40);
            step(($urandom_range(0, 149) == 0), kind[0], kind[1], 4'($urandom), r_addr, r_data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
